// File: rtl/regfile_wb_sched.sv
// ============================================================================
// Module  : regfile_wb_sched
// Purpose : Round-robin write-back arbiter for the register file write port,
//           with a pending-write scoreboard for RAW hazard detection.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] wn0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] wn1_i,
    input  logic [DATA_W-1:0] wd1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic [ADDR_W-1:0] wn_o,
    output logic              write_o,
    output logic [DATA_W-1:0] wd_o,
    input  logic              rsv_i,
    input  logic [ADDR_W-1:0] rsvn_i,
    input  logic [ADDR_W-1:0] rn1_i,
    input  logic [ADDR_W-1:0] rn2_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    localparam int NREG = 1 << ADDR_W;

    // last_q names the requester granted most recently (1 after reset).
    logic              last_q,  last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] wn_q,    wn_d;
    logic [DATA_W-1:0] wd_q,    wd_d;
    logic [NREG-1:0]   busy_q,  busy_d;

    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_wn;
    logic [DATA_W-1:0] w_sel_wd;

    // Grants are gated by reset so nothing is granted while it is asserted.
    assign gnt0_o   = rst_n_i & req0_i & (~req1_i | last_q);
    assign gnt1_o   = rst_n_i & req1_i & (~req0_i | ~last_q);
    assign w_xfer   = gnt0_o | gnt1_o;
    assign w_sel_wn = gnt1_o ? wn1_i : wn0_i;
    assign w_sel_wd = gnt1_o ? wd1_i : wd0_i;

    always_comb begin
        last_d  = last_q;
        write_d = 1'b0;
        wn_d    = wn_q;
        wd_d    = wd_q;
        if (w_xfer) begin
            last_d  = gnt1_o;
            write_d = (w_sel_wn != '0);
            wn_d    = w_sel_wn;
            wd_d    = w_sel_wd;
        end
    end

    // Clear first, then set, so a same-edge reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (write_q)
            busy_d[wn_q] = 1'b0;
        if (rsv_i && (rsvn_i != '0))
            busy_d[rsvn_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q  <= 1'b1;
            write_q <= 1'b0;
            wn_q    <= '0;
            wd_q    <= '0;
            busy_q  <= '0;
        end else begin
            last_q  <= last_d;
            write_q <= write_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
        end
    end

    assign wn_o    = wn_q;
    assign wd_o    = wd_q;
    assign write_o = write_q;
    assign busy1_o = busy_q[rn1_i];
    assign busy2_o = busy_q[rn2_i];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
// ============================================================================
// Module  : tb_regfile_wb_sched
// Purpose : Directed and randomized checks of regfile_wb_sched against a model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_sched;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1, rsv;
    logic [ADDR_W-1:0] wn0, wn1, rsvn, rn1, rn2;
    logic [DATA_W-1:0] wd0, wd1;
    logic              gnt0, gnt1, write, busy1, busy2;
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] wd;

    int checks = 0;
    int errors = 0;

    // Reference state: who was granted last, outstanding reservations, write stage.
    int                m_last;
    bit                m_busy [32];
    bit                m_write;
    logic [ADDR_W-1:0] m_wn;
    logic [DATA_W-1:0] m_wd;

    logic              o_gnt0, o_gnt1, o_write, o_busy1, o_busy2;
    logic [ADDR_W-1:0] o_wn;
    logic [DATA_W-1:0] o_wd;

    logic [DATA_W-1:0] rf [32];

    always #5 clk = ~clk;

    // Register-file stand-in fed by the scheduler's write port.
    always @(posedge clk) if (write && wn != 0) rf[wn] <= wd;

    regfile_wb_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_i(req0), .wn0_i(wn0), .wd0_i(wd0),
        .req1_i(req1), .wn1_i(wn1), .wd1_i(wd1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .wn_o(wn), .write_o(write), .wd_o(wd),
        .rsv_i(rsv), .rsvn_i(rsvn), .rn1_i(rn1), .rn2_i(rn2),
        .busy1_o(busy1), .busy2_o(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_write = 0;
        m_wn    = '0;
        m_wd    = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; rsv = 0;
        wn0 = '0; wn1 = '0; wd0 = '0; wd1 = '0;
        rsvn = '0; rn1 = '0; rn2 = '0;
    endtask

    // One clock: sample and check at the falling edge, then advance the model.
    task automatic cycle();
        bit eg0, eg1;
        @(negedge clk);
        eg0 = req0 && (!req1 || m_last == 1);
        eg1 = req1 && (!req0 || m_last == 0);
        o_gnt0 = gnt0; o_gnt1 = gnt1; o_write = write;
        o_wn = wn; o_wd = wd; o_busy1 = busy1; o_busy2 = busy2;
        chk("gnt0",  o_gnt0,  eg0);
        chk("gnt1",  o_gnt1,  eg1);
        chk("write", o_write, m_write);
        chk("wn",    o_wn,    m_wn);
        chk("wd",    o_wd,    m_wd);
        chk("busy1", o_busy1, m_busy[rn1]);
        chk("busy2", o_busy2, m_busy[rn2]);
        @(posedge clk);
        if (m_write) m_busy[m_wn] = 0;
        if (rsv && rsvn != 0) m_busy[rsvn] = 1;
        if (eg0 || eg1) begin
            m_wn    = eg1 ? wn1 : wn0;
            m_wd    = eg1 ? wd1 : wd0;
            m_write = (m_wn != 0);
            m_last  = eg1 ? 1 : 0;
        end else begin
            m_write = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_write", write, 1'b0);
        chk("rst_wn", wn, '0);
        chk("rst_wd", wd, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        bit p0, p1;
        idle_inputs();
        do_reset();

        // Single write from requester 0.
        req0 = 1; wn0 = 5'd1; wd0 = 32'd32;
        cycle();
        chk("t1_gnt0", o_gnt0, 1'b1);
        idle_inputs();
        cycle();
        chk("t1_write", o_write, 1'b1);
        chk("t1_wn", o_wn, 5'd1);
        chk("t1_wd", o_wd, 32'd32);
        cycle();
        chk("t1_rf1", rf[1], 32'd32);

        // Sustained contention alternates starting with requester 0.
        do_reset();
        req0 = 1; wn0 = 5'd1; wd0 = 32'd32;
        req1 = 1; wn1 = 5'd2; wd1 = 32'd32;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_gnt0_alt", o_gnt0, (i % 2 == 0));
            if (i > 0) chk("t2_write_cont", o_write, 1'b1);
        end
        idle_inputs();
        cycle();
        chk("t2_write_last", o_write, 1'b1);
        cycle();
        chk("t2_rf1", rf[1], 32'd32);
        chk("t2_rf2", rf[2], 32'd32);

        // Write to register 0 is granted, not issued, and moves the pointer.
        req0 = 1; wn0 = 5'd4; wd0 = 32'd1;
        cycle();
        idle_inputs();
        req1 = 1; wn1 = 5'd0; wd1 = 32'd55;
        cycle();
        chk("t3_gnt1", o_gnt1, 1'b1);
        idle_inputs();
        cycle();
        chk("t3_write0", o_write, 1'b0);
        req0 = 1; wn0 = 5'd6; wd0 = 32'd7;
        req1 = 1; wn1 = 5'd8; wd1 = 32'd9;
        cycle();
        chk("t3_next_gnt0", o_gnt0, 1'b1);
        idle_inputs();
        cycle();

        // Reservation lifetime: Busy from cycle 1 until after the Write cycle.
        rsv = 1; rsvn = 5'd5; rn1 = 5'd5;
        cycle();
        rsv = 0;
        cycle(); chk("t4_busy_c1", o_busy1, 1'b1);
        cycle(); chk("t4_busy_c2", o_busy1, 1'b1);
        req0 = 1; wn0 = 5'd5; wd0 = 32'hA5;
        cycle(); chk("t4_gnt_c3", o_gnt0, 1'b1);
        req0 = 0;
        cycle(); chk("t4_busy_c4", o_busy1, 1'b1);
        cycle(); chk("t4_busy_c5", o_busy1, 1'b0);

        // Same-edge set and clear on register 7: set wins.
        rsv = 1; rsvn = 5'd7;
        cycle();
        rsv = 0; req0 = 1; wn0 = 5'd7; wd0 = 32'h77;
        cycle();
        req0 = 0; rsv = 1; rsvn = 5'd7; rn2 = 5'd7;
        cycle();
        chk("t5_write7", o_write, 1'b1);
        rsv = 0;
        cycle();
        chk("t5_busy7", o_busy2, 1'b1);

        // Asynchronous reset in the middle of a pending write.
        idle_inputs();
        rsv = 1; rsvn = 5'd3;
        cycle();
        rsv = 0; req0 = 1; wn0 = 5'd3; wd0 = 32'h33;
        cycle();
        req0 = 1; req1 = 1; wn0 = 5'd9; wn1 = 5'd10; rn1 = 5'd3;
        #1;
        chk("t6_pre_write", write, 1'b1);
        chk("t6_pre_busy", busy1, 1'b1);
        rst_n = 0;
        #1;
        chk("t6_write_drop", write, 1'b0);
        chk("t6_busy_lost", busy1, 1'b0);
        chk("t6_gnt_off", {gnt1, gnt0}, 2'b00);
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        cycle();
        chk("t6_first_gnt0", o_gnt0, 1'b1);
        idle_inputs();

        // Randomized traffic; a pending ungranted request keeps its payload.
        p0 = 0; p1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(p0 && ($urandom_range(7) != 0))) begin
                req0 = 1'($urandom_range(1)); wn0 = 5'($urandom); wd0 = $urandom;
            end
            if (!(p1 && ($urandom_range(7) != 0))) begin
                req1 = 1'($urandom_range(1)); wn1 = 5'($urandom); wd1 = $urandom;
            end
            rsv = 1'($urandom_range(1)); rsvn = 5'($urandom);
            rn1 = 5'($urandom); rn2 = 5'($urandom);
            cycle();
            p0 = req0 && !o_gnt0;
            p1 = req1 && !o_gnt1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
